// File: rtl/inst_issuer.sv
// Instruction issue stage: buffers host instructions in a FIFO and issues them to the
// decoder, holding back drain (MMUL_D) hazards and dropping/counting illegal opcodes.
package inst_issuer_pkg;
  localparam int OP_W  = 4;
  localparam int REG_W = 4;

  localparam logic [OP_W-1:0] MMUL_D  = 4'd1;
  localparam logic [OP_W-1:0] MMUL_ND = 4'd2;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dest;
  } instruction_t;
endpackage

module inst_issuer
  import inst_issuer_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  instruction_t             host_inst_i,
  input  logic                     host_valid_i,
  output logic                     host_ready_o,
  input  logic                     flush_i,
  input  logic                     array_stall_i,
  output instruction_t             inst_o,
  output logic                     inst_valid_o,
  output logic                     drain_busy_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [7:0]               illegal_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  instruction_t     mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [DW-1:0]    drain_cnt_reg;
  logic [REG_W-1:0] drain_dest_reg;
  instruction_t     inst_reg;
  logic             valid_reg;
  logic [7:0]       illegal_reg;

  instruction_t head;
  state_t       state;
  logic         head_legal;
  logic         hazard;
  logic         push;
  logic         pop;
  logic         issue_legal;
  logic         issue_illegal;

  assign head       = mem[rd_ptr_reg];
  assign head_legal = (head.op == MMUL_D) || (head.op == MMUL_ND);
  assign hazard     = (drain_cnt_reg != '0) &&
                      ((head.op == MMUL_D) ||
                       (head.src1 == drain_dest_reg) ||
                       (head.src2 == drain_dest_reg));

  assign host_ready_o = (count_reg < CW'(DEPTH)) & ~flush_i & ~rst_i;
  assign push         = host_valid_i & host_ready_o;

  // Issue decision is re-evaluated every cycle from the current FIFO head;
  // illegal opcodes bypass the hazard check since they never reach the array.
  always_comb begin
    state         = IDLE;
    pop           = 1'b0;
    issue_legal   = 1'b0;
    issue_illegal = 1'b0;
    if (array_stall_i) begin
      state = HOLD;
    end else if (count_reg == '0) begin
      state = IDLE;
    end else if (head_legal && hazard) begin
      state = HOLD;
    end else begin
      state = ISSUE;
    end
    if (state == ISSUE && !flush_i) begin
      pop           = 1'b1;
      issue_legal   = head_legal;
      issue_illegal = ~head_legal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= host_inst_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      drain_cnt_reg  <= '0;
      drain_dest_reg <= '0;
      inst_reg       <= '0;
      valid_reg      <= 1'b0;
      illegal_reg    <= '0;
    end else if (flush_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      drain_cnt_reg <= '0;
      valid_reg     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase

      // A stall freezes the drain countdown along with the issue path.
      if (issue_legal && head.op == MMUL_D) begin
        drain_cnt_reg  <= DW'(DRAIN_CYCLES);
        drain_dest_reg <= head.dest;
      end else if (!array_stall_i && drain_cnt_reg != '0) begin
        drain_cnt_reg <= drain_cnt_reg - DW'(1);
      end

      valid_reg <= issue_legal;
      if (issue_legal) begin
        inst_reg <= head;
      end
      if (issue_illegal && illegal_reg != 8'hFF) begin
        illegal_reg <= illegal_reg + 8'd1;
      end
    end
  end

  assign inst_o        = inst_reg;
  assign inst_valid_o  = valid_reg;
  assign drain_busy_o  = (drain_cnt_reg != '0);
  assign count_o       = count_reg;
  assign illegal_cnt_o = illegal_reg;

endmodule

// File: tb/tb_inst_issuer.sv
// Bench for inst_issuer: directed scenarios plus random traffic, all checked against a
// queue-based behavioural model of the issue rules.
module tb_inst_issuer;
  import inst_issuer_pkg::*;

  localparam int DEPTH = 8;
  localparam int DRAIN = 4;

  logic         clk = 1'b0;
  logic         rst;
  instruction_t host_inst;
  logic         host_valid;
  logic         host_ready;
  logic         flush;
  logic         stall;
  instruction_t inst;
  logic         inst_valid;
  logic         drain_busy;
  logic [3:0]   count;
  logic [7:0]   illegal_cnt;

  always #5 clk = ~clk;

  inst_issuer #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .host_inst_i  (host_inst),
    .host_valid_i (host_valid),
    .host_ready_o (host_ready),
    .flush_i      (flush),
    .array_stall_i(stall),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .drain_busy_o (drain_busy),
    .count_o      (count),
    .illegal_cnt_o(illegal_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  instruction_t     q[$];
  int               m_drain;
  logic [REG_W-1:0] m_ddest;
  int               m_illegal;
  instruction_t     m_inst;
  bit               m_valid;

  instruction_t nop_i = '0;

  function automatic instruction_t mk(input logic [OP_W-1:0] op, input int s1, input int s2,
                                      input int d);
    instruction_t t;
    t.op   = op;
    t.src1 = REG_W'(s1);
    t.src2 = REG_W'(s2);
    t.dest = REG_W'(d);
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drain   = 0;
    m_ddest   = '0;
    m_illegal = 0;
    m_inst    = '0;
    m_valid   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, inst_valid, 0);
    check({tag, "_inst"}, inst, 0);
    check({tag, "_busy"}, drain_busy, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_illegal"}, illegal_cnt, 0);
    check({tag, "_ready"}, host_ready, 0);
  endtask

  // One clock: drive inputs, predict with the model, cross the edge, compare.
  task automatic step(input bit p, input instruction_t pin, input bit st, input bit fl);
    bit ready;
    bit load;
    host_valid = p;
    host_inst  = pin;
    stall      = st;
    flush      = fl;
    #1;
    ready = (q.size() < DEPTH) && !fl;
    check("host_ready", host_ready, ready);
    m_valid = 0;
    load    = 0;
    if (fl) begin
      q.delete();
      m_drain = 0;
    end else begin
      if (q.size() != 0 && !st) begin
        if (!(q[0].op inside {MMUL_D, MMUL_ND})) begin
          void'(q.pop_front());
          if (m_illegal < 255) m_illegal++;
        end else if (m_drain == 0 ||
                     (q[0].op != MMUL_D && q[0].src1 != m_ddest && q[0].src2 != m_ddest)) begin
          m_inst  = q.pop_front();
          m_valid = 1;
          if (m_inst.op == MMUL_D) begin
            m_drain = DRAIN;
            m_ddest = m_inst.dest;
            load    = 1;
          end
        end
      end
      if (!load && !st && m_drain > 0) m_drain--;
      if (p && ready) q.push_back(pin);
    end
    @(posedge clk);
    #1;
    cyc++;
    check("inst_valid", inst_valid, m_valid);
    check("inst", inst, m_inst);
    check("count", count, q.size());
    check("drain_busy", drain_busy, m_drain != 0);
    check("illegal_cnt", illegal_cnt, m_illegal);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, nop_i, 0, 0);
  endtask

  // MMUL_D (dest 5) followed by an instruction reading src1; returns edges to second issue.
  task automatic drain_case(input int s1, input int stall_from, input int stall_len,
                            input int exp_gap, input string tag);
    int n0;
    int gap;
    step(1, mk(MMUL_D, 0, 0, 5), 0, 0);
    step(1, mk(MMUL_ND, s1, 7, 8), 0, 0);
    check({tag, "_first"}, inst_valid, 1);
    n0  = cyc;
    gap = -1;
    for (int k = 1; k <= 20; k++) begin
      step(0, nop_i, (k >= stall_from) && (k < stall_from + stall_len), 0);
      if (inst_valid === 1'b1) begin
        gap = cyc - n0;
        break;
      end
    end
    check({tag, "_gap"}, gap, exp_gap);
    idle(6);
  endtask

  int           vcount;
  int           r;
  logic [OP_W-1:0] rop;

  initial begin
    rst        = 1'b1;
    host_valid = 1'b0;
    host_inst  = '0;
    flush      = 1'b0;
    stall      = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("rst_init");
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_ready_held", host_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", host_ready, 1);
    @(posedge clk);
    #1;

    // Single issue
    step(1, mk(MMUL_ND, 1, 2, 3), 0, 0);
    check("single_count", count, 1);
    step(0, nop_i, 0, 0);
    check("single_valid", inst_valid, 1);
    check("single_inst", inst, mk(MMUL_ND, 1, 2, 3));
    check("single_drained", count, 0);
    step(0, nop_i, 0, 0);
    check("single_pulse_end", inst_valid, 0);

    // Fill under stall, ninth push refused, then drain in order
    for (int i = 0; i < 9; i++) step(1, mk(MMUL_ND, i, i + 1, 9), 1, 0);
    check("full_count", count, 8);
    check("full_ready", host_ready, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, nop_i, 0, 0);
      check("full_order_valid", inst_valid, 1);
      check("full_order_src1", inst.src1, i);
    end
    step(0, nop_i, 0, 0);
    check("full_empty_valid", inst_valid, 0);

    // Drain hazards
    drain_case(5, 99, 0, 5, "dep");
    drain_case(6, 99, 0, 1, "indep");
    drain_case(5, 2, 2, 7, "stall_dep");

    // Illegal opcodes
    vcount = 0;
    step(1, mk(4'd0, 1, 1, 1), 0, 0);
    step(1, mk(4'd3, 1, 1, 1), 0, 0);
    vcount += int'(inst_valid);
    step(1, mk(4'd15, 1, 1, 1), 0, 0);
    vcount += int'(inst_valid);
    step(1, mk(MMUL_ND, 1, 1, 1), 0, 0);
    vcount += int'(inst_valid);
    for (int k = 0; k < 3; k++) begin
      step(0, nop_i, 0, 0);
      vcount += int'(inst_valid);
    end
    check("illegal_count3", illegal_cnt, 3);
    check("illegal_one_pulse", vcount, 1);

    // Flush with drain pending and 4 queued
    step(1, mk(MMUL_D, 0, 0, 9), 0, 0);
    step(1, mk(MMUL_ND, 9, 0, 1), 0, 0);
    for (int k = 0; k < 3; k++) step(1, mk(MMUL_ND, 9, 0, 1), 1, 0);
    check("preflush_count", count, 4);
    check("preflush_busy", drain_busy, 1);
    step(1, mk(MMUL_ND, 1, 1, 1), 0, 1);
    check("flush_count", count, 0);
    check("flush_busy", drain_busy, 0);
    check("flush_valid", inst_valid, 0);
    vcount = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, nop_i, 0, 0);
      vcount += int'(inst_valid);
    end
    check("flush_no_valids", vcount, 0);
    check("flush_illegal_kept", illegal_cnt, 3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) rop = MMUL_ND;
      else if (r < 8) rop = MMUL_D;
      else rop = OP_W'($urandom_range(3, 15));
      step($urandom_range(0, 9) < 7,
           mk(rop, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
           $urandom_range(0, 9) < 2, $urandom_range(0, 49) == 0);
    end
    idle(40);

    // Saturation of the illegal counter
    for (int i = 0; i < 260; i++) step(1, mk(4'd15, 0, 0, 0), 0, 0);
    idle(2);
    check("illegal_saturated", illegal_cnt, 255);

    // Asynchronous reset mid-drain with 3 queued
    step(0, nop_i, 0, 1);
    idle(6);
    step(1, mk(MMUL_D, 0, 0, 2), 0, 0);
    step(1, mk(MMUL_ND, 2, 0, 1), 0, 0);
    step(1, mk(MMUL_ND, 2, 0, 1), 0, 0);
    step(1, mk(MMUL_ND, 2, 0, 1), 0, 0);
    check("prerst_busy", drain_busy, 1);
    check("prerst_count", count, 3);
    host_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst2", host_ready, 1);
    @(posedge clk);
    #1;
    step(1, mk(MMUL_ND, 4, 5, 6), 0, 0);
    step(0, nop_i, 0, 0);
    check("post_rst_issue", inst, mk(MMUL_ND, 4, 5, 6));
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
